// File: rtl/oam_dma_engine.sv
// OAM DMA engine: a write to 0xFF46 copies NUM_BYTES bytes from page {SRC,8'h00}
// into OAM at 0xFE00, one read phase plus one write cycle per byte.
module oam_dma_engine #(
  parameter int NUM_BYTES   = 160,
  parameter int RD_LAT      = 1,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] reg_addr_select,
  input  logic [7:0]  reg_write_value,
  input  logic        reg_write_enable,
  output logic [7:0]  reg_read_out,
  output logic [15:0] dma_addr_select,
  output logic [7:0]  dma_write_value,
  output logic        dma_write_enable,
  input  logic [7:0]  dma_read_out,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_DELAY  = 2'd1;
  localparam logic [1:0]  S_READ   = 2'd2;
  localparam logic [1:0]  S_WRITE  = 2'd3;
  localparam logic [1:0]  S_START  = (START_DELAY > 0) ? S_DELAY : S_READ;

  localparam logic [7:0]  LAST_IDX  = 8'(NUM_BYTES - 1);
  localparam logic [15:0] DLY_LAST  = 16'((START_DELAY > 0) ? (START_DELAY - 1) : 0);
  localparam logic [15:0] RD_LAST   = 16'(RD_LAT);
  localparam logic [15:0] DMA_REG   = 16'hFF46;
  localparam logic [15:0] IDLE_ADDR = 16'hFFFF;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;

  logic [1:0]  r_state;
  logic [7:0]  r_src;
  logic [7:0]  r_idx;
  logic [7:0]  r_data;
  logic [15:0] r_cnt;
  logic        r_done;

  logic        w_trigger;
  logic [7:0]  w_eff_hi;
  logic [15:0] w_src_addr;
  logic [15:0] w_dst_addr;

  assign w_trigger  = reg_write_enable && (reg_addr_select == DMA_REG);
  // Echo/shadow pages E0..FF fold back onto C0..DF.
  assign w_eff_hi   = (r_src < 8'hE0) ? r_src : (r_src - 8'h20);
  assign w_src_addr = {w_eff_hi, r_idx};
  assign w_dst_addr = OAM_BASE + {8'h00, r_idx};

  // Transfer sequencer; a trigger always restarts from byte 0, even mid-transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_src   <= 8'hFF;
      r_idx   <= 8'h00;
      r_data  <= 8'h00;
      r_cnt   <= 16'h0000;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_trigger) begin
        r_src   <= reg_write_value;
        r_idx   <= 8'h00;
        r_cnt   <= 16'h0000;
        r_state <= S_START;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= 16'h0000;
          end
          S_DELAY: begin
            if (r_cnt == DLY_LAST) begin
              r_cnt   <= 16'h0000;
              r_state <= S_READ;
            end else begin
              r_cnt <= r_cnt + 16'h0001;
            end
          end
          S_READ: begin
            if (r_cnt == RD_LAST) begin
              r_cnt   <= 16'h0000;
              r_data  <= dma_read_out;
              r_state <= S_WRITE;
            end else begin
              r_cnt <= r_cnt + 16'h0001;
            end
          end
          S_WRITE: begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= 8'h00;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 8'h01;
              r_state <= S_READ;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Bus outputs decoded from registered state; a coincident trigger cancels the write.
  always_comb begin
    dma_addr_select  = IDLE_ADDR;
    dma_write_value  = 8'h00;
    dma_write_enable = 1'b0;
    case (r_state)
      S_READ: begin
        dma_addr_select = w_src_addr;
      end
      S_WRITE: begin
        dma_addr_select  = w_dst_addr;
        dma_write_value  = r_data;
        dma_write_enable = !w_trigger;
      end
      default: begin
        dma_addr_select = IDLE_ADDR;
      end
    endcase
  end

  // MMIO readback of the source register.
  always_comb begin
    if (reg_addr_select == DMA_REG) begin
      reg_read_out = r_src;
    end else begin
      reg_read_out = 8'hFF;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: memory model plus scoreboard of expected OAM writes.
module tb_oam_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] reg_addr_select;
  logic [7:0]  reg_write_value;
  logic        reg_write_enable;
  logic [7:0]  reg_read_out;
  logic [15:0] dma_addr_select;
  logic [7:0]  dma_write_value;
  logic        dma_write_enable;
  logic [7:0]  dma_read_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  oam_dma_engine dut (
    .clk              (clk),
    .rst              (rst),
    .reg_addr_select  (reg_addr_select),
    .reg_write_value  (reg_write_value),
    .reg_write_enable (reg_write_enable),
    .reg_read_out     (reg_read_out),
    .dma_addr_select  (dma_addr_select),
    .dma_write_value  (dma_write_value),
    .dma_write_enable (dma_write_enable),
    .dma_read_out     (dma_read_out),
    .busy             (busy),
    .done             (done)
  );

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [15:0] h0 = 16'hFFFF;
  logic [15:0] h1 = 16'hFFFF;
  logic [7:0]  rd_q;
  logic [7:0]  oam [0:255];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    case (a[15:8])
      8'hC0:   return a[7:0] ^ 8'h5A;
      8'hD0:   return a[7:0] ^ 8'h3C;
      8'hDE:   return a[7:0] ^ 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] eff_hi(input logic [7:0] v);
    return (v < 8'hE0) ? v : (v - 8'h20);
  endfunction

  // Memory path with one cycle of read latency; OAM captures bus writes.
  always @(posedge clk) begin
    cyc++;
    rd_q <= src_byte(dma_addr_select);
    if (dma_write_enable && dma_addr_select[15:8] == 8'hFE) begin
      oam[dma_addr_select[7:0]] <= dma_write_value;
    end
  end
  assign dma_read_out = rd_q;

  // Monitor: compare every bus write against the scoreboard, time the done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!busy) begin
      check_val("idle_addr", {16'h0000, dma_addr_select}, 32'h0000FFFF);
      check_val("idle_we", {31'h0, dma_write_enable}, 32'h0);
    end else begin
      busy_cnt++;
    end
    if (dma_write_enable) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check_val("unexpected_write", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        check_val("wr_addr", {16'h0000, dma_addr_select}, {16'h0000, e.dst});
        check_val("wr_data", {24'h0, dma_write_value}, {24'h0, e.data});
        check_val("read_prev1", {16'h0000, h0}, {16'h0000, e.src});
        check_val("read_prev2", {16'h0000, h1}, {16'h0000, e.src});
      end
    end
    if (done) begin
      done_cnt++;
      check_val("done_latency", cyc - trig_cyc, 32'd481);
      check_val("busy_cycles", busy_cnt, 32'd481);
      check_val("sb_empty_at_done", sb.size(), 32'd0);
    end
    h1 = h0;
    h0 = dma_addr_select;
  end

  task automatic reg_write(input logic [15:0] a, input logic [7:0] v);
    @(posedge clk);
    #1;
    reg_addr_select  = a;
    reg_write_value  = v;
    reg_write_enable = 1'b1;
    if (a == 16'hFF46) begin
      sb.delete();
      for (int i = 0; i < 160; i++) begin
        exp_t e;
        e.src  = {eff_hi(v), 8'(i)};
        e.dst  = 16'hFE00 + 16'(i);
        e.data = src_byte(e.src);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    reg_write_enable = 1'b0;
    reg_addr_select  = 16'h0000;
    if (a == 16'hFF46) begin
      trig_cyc = cyc;
      busy_cnt = 0;
    end
  endtask

  task automatic wait_done(input int max);
    int d;
    d = done_cnt;
    for (int i = 0; i < max && done_cnt == d; i++) @(posedge clk);
    check_val("done_seen", {31'h0, done_cnt != d}, 32'h1);
  endtask

  task automatic wait_writes(input int target, input int max);
    for (int i = 0; i < max && wr_cnt < target; i++) @(posedge clk);
    check_val("writes_reached", {31'h0, wr_cnt >= target}, 32'h1);
  endtask

  task automatic check_oam(input string tag, input logic [7:0] v);
    int bad;
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      if (oam[i] !== src_byte({eff_hi(v), 8'(i)})) bad++;
    end
    check_val(tag, bad, 32'd0);
  endtask

  initial begin
    int w0;
    int d0;
    rst = 1'b0;
    reg_addr_select  = 16'hFF46;
    reg_write_value  = 8'h00;
    reg_write_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_addr", {16'h0000, dma_addr_select}, 32'h0000FFFF);
    check_val("rst_we", {31'h0, dma_write_enable}, 32'h0);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_done", {31'h0, done}, 32'h0);
    check_val("rst_reg", {24'h0, reg_read_out}, 32'hFF);
    rst = 1'b1;
    reg_addr_select = 16'h0000;

    // Basic copy from C000
    w0 = wr_cnt;
    reg_write(16'hFF46, 8'hC0);
    wait_done(1000);
    check_val("t1_write_count", wr_cnt - w0, 32'd160);
    check_oam("t1_oam", 8'hC0);

    // Remapped source FE -> DE, plus register readback
    w0 = wr_cnt;
    reg_write(16'hFF46, 8'hFE);
    reg_addr_select = 16'hFF46;
    #1;
    check_val("t3_read_ff46", {24'h0, reg_read_out}, 32'hFE);
    reg_addr_select = 16'hFF47;
    #1;
    check_val("t3_read_ff47", {24'h0, reg_read_out}, 32'hFF);
    reg_addr_select = 16'h0000;
    wait_done(1000);
    check_val("t3_write_count", wr_cnt - w0, 32'd160);
    check_oam("t3_oam", 8'hFE);

    // Retrigger mid-transfer
    d0 = done_cnt;
    w0 = wr_cnt;
    reg_write(16'hFF46, 8'hC0);
    wait_writes(w0 + 50, 1000);
    reg_write(16'hFF46, 8'hD0);
    wait_done(1000);
    check_val("t4_done_count", done_cnt - d0, 32'd1);
    check_oam("t4_oam", 8'hD0);

    // Reset during byte 30
    d0 = done_cnt;
    w0 = wr_cnt;
    reg_write(16'hFF46, 8'hC0);
    wait_writes(w0 + 29, 1000);
    #1;
    rst = 1'b0;
    #1;
    check_val("t5_we", {31'h0, dma_write_enable}, 32'h0);
    check_val("t5_addr", {16'h0000, dma_addr_select}, 32'h0000FFFF);
    check_val("t5_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    w0 = wr_cnt;
    busy_cnt = 0;
    repeat (30) @(posedge clk);
    #1;
    check_val("t5_no_writes", wr_cnt - w0, 32'd0);
    check_val("t5_no_busy", busy_cnt, 32'd0);
    check_val("t5_no_done", done_cnt - d0, 32'd0);
    reg_addr_select = 16'hFF46;
    #1;
    check_val("t5_reg", {24'h0, reg_read_out}, 32'hFF);
    reg_addr_select = 16'h0000;

    // Write to a neighbouring address does nothing
    w0 = wr_cnt;
    busy_cnt = 0;
    reg_write(16'hFF45, 8'hC0);
    repeat (10) @(posedge clk);
    #1;
    check_val("t6_no_busy", busy_cnt, 32'd0);
    check_val("t6_no_writes", wr_cnt - w0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
